memseq: RTL and testbench

Memory-cycle sequencer for the CADR main-memory port. It arbitrates between the CPU (microcode memory read/write issued in the fetch phase) and the spy/debug port, and drives the single outstanding bus request. It generates the `loadmd`/`memrq` strobes that clock returned data into the memory data register, and the `memwait` stall back to the CPU.

---
 rtl/memseq_pkg.sv | 18 +
 rtl/memseq_arb.sv | 35 +++
 rtl/memseq.sv | 126 ++++++++++++
 tb/tb_memseq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/memseq_pkg.sv
// Shared types and constants for the memseq memory-cycle sequencer.
package memseq_pkg;

   localparam int ADDR_W       = 22;
   localparam int STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LOAD = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_SPY = 1'b1
   } owner_t;

endpackage

// File: rtl/memseq_arb.sv
// CPU/spy arbiter: CPU wins by default, spy forced through after STARVE_LIMIT
// CPU grants made while it was waiting.
module memseq_arb
   import memseq_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic idle,
   input  logic cpu_cand,
   input  logic spy_cand,
   output logic grant_cpu,
   output logic grant_spy,
   output logic cpu_lost
);

   logic [2:0] starve;
   logic       spy_first;

   assign spy_first = (starve >= 3'(STARVE_LIMIT));
   assign grant_spy = idle & spy_cand & (~cpu_cand | spy_first);
   assign grant_cpu = idle & cpu_cand & ~grant_spy;
   assign cpu_lost  = idle & cpu_cand & grant_spy;

   // Cannot pass the limit: once it is reached a pending spy always wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve <= 3'd0;
      end else if (grant_spy) begin
         starve <= 3'd0;
      end else if (grant_cpu && spy_cand) begin
         starve <= starve + 3'd1;
      end
   end

endmodule

// File: rtl/memseq.sv
// CADR main-memory cycle sequencer (IDLE -> REQ -> [LOAD] -> IDLE).
// Optional REQ timeout enabled by defining MEMSEQ_TIMEOUT_EN.
module memseq
   import memseq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              state_fetch,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_vma,
   input  logic              spy_rd,
   input  logic              spy_wr,
   input  logic [ADDR_W-1:0] spy_addr,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              loadmd,
   output logic              memrq,
   output logic              memwait,
   output logic              spy_done,
   output logic              mem_timeout
);

   state_t state;
   owner_t owner;
   logic   cpu_cand, spy_cand;
   logic   grant_cpu, grant_spy, cpu_lost;
   logic   abort;

   assign cpu_cand = state_fetch & (cpu_rd | cpu_wr);
   assign spy_cand = spy_rd | spy_wr;

   memseq_arb u_arb (
      .clk       (clk),
      .reset     (reset),
      .idle      (state == IDLE),
      .cpu_cand  (cpu_cand),
      .spy_cand  (spy_cand),
      .grant_cpu (grant_cpu),
      .grant_spy (grant_spy),
      .cpu_lost  (cpu_lost)
   );

`ifdef MEMSEQ_TIMEOUT_EN
   logic [9:0] to_cnt;

   // Held at zero outside REQ, so it starts from zero on every REQ entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= 10'd0;
      end else if (state != REQ) begin
         to_cnt <= 10'd0;
      end else begin
         to_cnt <= to_cnt + 10'd1;
      end
   end

   assign abort = (state == REQ) & ~mem_ack & ((to_cnt + 10'd1) == 10'(TIMEOUT_CYCLES));
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= OWN_CPU;
         mem_req     <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         loadmd      <= 1'b0;
         spy_done    <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         loadmd      <= 1'b0;
         spy_done    <= 1'b0;
         mem_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_cpu) begin
                  state     <= REQ;
                  owner     <= OWN_CPU;
                  mem_req   <= 1'b1;
                  mem_addr  <= cpu_vma;
                  mem_write <= cpu_wr;
               end else if (grant_spy) begin
                  state     <= REQ;
                  owner     <= OWN_SPY;
                  mem_req   <= 1'b1;
                  mem_addr  <= spy_addr;
                  mem_write <= spy_wr;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (mem_write) begin
                     state     <= IDLE;
                     mem_write <= 1'b0;
                     spy_done  <= (owner == OWN_SPY);
                  end else begin
                     state    <= LOAD;
                     loadmd   <= 1'b1;
                     spy_done <= (owner == OWN_SPY);
                  end
               end else if (abort) begin
                  state       <= IDLE;
                  mem_req     <= 1'b0;
                  mem_write   <= 1'b0;
                  mem_timeout <= 1'b1;
                  spy_done    <= (owner == OWN_SPY);
               end
            end
            LOAD: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign memrq   = loadmd;
   assign memwait = ((state != IDLE) & (owner == OWN_CPU)) | cpu_lost;

endmodule

// File: tb/tb_memseq.sv
// Directed self-checking bench for memseq; outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_memseq;

   logic        clk = 1'b0;
   logic        reset;
   logic        state_fetch, cpu_rd, cpu_wr, spy_rd, spy_wr, mem_ack;
   logic [21:0] cpu_vma, spy_addr;
   logic        mem_req, mem_write, loadmd, memrq, memwait, spy_done, mem_timeout;
   logic [21:0] mem_addr;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   memseq #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .state_fetch (state_fetch),
      .cpu_rd      (cpu_rd),
      .cpu_wr      (cpu_wr),
      .cpu_vma     (cpu_vma),
      .spy_rd      (spy_rd),
      .spy_wr      (spy_wr),
      .spy_addr    (spy_addr),
      .mem_ack     (mem_ack),
      .mem_req     (mem_req),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .loadmd      (loadmd),
      .memrq       (memrq),
      .memwait     (memwait),
      .spy_done    (spy_done),
      .mem_timeout (mem_timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic cpu_drop();
      state_fetch = 1'b0;
      cpu_rd      = 1'b0;
      cpu_wr      = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      state_fetch = 0; cpu_rd = 0; cpu_wr = 0; spy_rd = 0; spy_wr = 0; mem_ack = 0;
      cpu_vma = '0; spy_addr = '0;
      step(); step();
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_outputs", {26'd0, mem_write, loadmd, memrq, memwait, spy_done, mem_timeout}, 32'd0);
      check("rst_addr", {10'd0, mem_addr}, 32'd0);
      reset = 1'b0;
      step();

      // CPU read, ack already high
      mem_ack = 1; state_fetch = 1; cpu_rd = 1; cpu_vma = 22'h000100;
      #1 check("rd_no_wait_idle", {31'd0, memwait}, 32'd0);
      step(); cpu_drop();
      check("rd_req", {29'd0, mem_req, mem_write, memwait}, 32'b101);
      check("rd_addr", {10'd0, mem_addr}, 32'h000100);
      step();
      check("rd_load", {28'd0, mem_req, loadmd, memrq, memwait}, 32'b0111);
      step();
      check("rd_done", {29'd0, mem_req, loadmd, memwait}, 32'b000);

      // CPU write, ack after 5 REQ cycles
      mem_ack = 0; state_fetch = 1; cpu_wr = 1; cpu_vma = 22'h2A5A5;
      step(); cpu_drop();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("wr_req%0d", i), {29'd0, mem_req, mem_write, loadmd}, 32'b110);
         if (i == 4) mem_ack = 1;
         if (i < 4) step();
      end
      check("wr_addr", {10'd0, mem_addr}, 32'h2A5A5);
      step();
      check("wr_done", {28'd0, mem_req, mem_write, loadmd, memwait}, 32'b0000);
      step();
      check("wr_no_load", {31'd0, loadmd}, 32'd0);

      // Starvation: spy read pending against continuous CPU reads
      spy_rd = 1; spy_addr = 22'h3FFFF0;
      for (int i = 0; i < 4; i++) begin
         state_fetch = 1; cpu_rd = 1; cpu_vma = 22'(i + 16);
         #1 check($sformatf("st_cpu_nolose%0d", i), {31'd0, memwait}, 32'd0);
         step(); cpu_drop();
         check($sformatf("st_cpu_addr%0d", i), {10'd0, mem_addr}, 32'(i + 16));
         check($sformatf("st_starve%0d", i), {29'd0, dut.u_arb.starve}, 32'(i + 1));
         step(); step();
      end
      state_fetch = 1; cpu_rd = 1; cpu_vma = 22'h000555;
      #1 check("st_cpu_lost_wait", {31'd0, memwait}, 32'd1);
      step(); cpu_drop();
      check("st_spy_addr", {10'd0, mem_addr}, 32'h3FFFF0);
      check("st_spy_req", {30'd0, mem_req, memwait}, 32'b10);
      check("st_starve_clr", {29'd0, dut.u_arb.starve}, 32'd0);
      step();
      check("st_spy_load", {30'd0, loadmd, spy_done}, 32'b11);
      spy_rd = 0;
      step();
      check("st_spy_idle", {29'd0, mem_req, loadmd, spy_done}, 32'b000);

      // rd and wr together: write wins
      state_fetch = 1; cpu_rd = 1; cpu_wr = 1; cpu_vma = 22'h0ABCDE;
      step(); cpu_drop();
      check("rw_req", {30'd0, mem_req, mem_write}, 32'b11);
      step();
      check("rw_done", {29'd0, mem_req, mem_write, loadmd}, 32'b000);
      step();
      check("rw_no_load", {31'd0, loadmd}, 32'd0);

      // Spy write completes with spy_done on the ack transition
      spy_wr = 1; spy_addr = 22'h012345;
      step();
      check("sw_req", {29'd0, mem_req, mem_write, memwait}, 32'b110);
      step();
      check("sw_done", {29'd0, mem_req, loadmd, spy_done}, 32'b001);
      spy_wr = 0;
      step();
      check("sw_idle", {30'd0, mem_req, spy_done}, 32'b00);

      // Reset in the middle of a spy write REQ
      mem_ack = 0; spy_wr = 1; spy_addr = 22'h0F0F0F;
      step();
      check("rs_req", {31'd0, mem_req}, 32'd1);
      #2 reset = 1;
      #1 check("rs_async_drop", {31'd0, mem_req}, 32'd0);
      spy_wr = 0;
      step(); step();
      reset = 0; mem_ack = 1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rs_quiet%0d", i), {29'd0, mem_req, loadmd, spy_done}, 32'b000);
         step();
      end
      check("rs_addr", {10'd0, mem_addr}, 32'd0);

      // No-ack read: timeout abort, or indefinite wait in the default build
      mem_ack = 0; state_fetch = 1; cpu_rd = 1; cpu_vma = 22'h000777;
      step(); cpu_drop();
`ifdef MEMSEQ_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         check($sformatf("to_req%0d", i), {29'd0, mem_req, mem_timeout, loadmd}, 32'b100);
         step();
      end
      check("to_pulse", {28'd0, mem_req, mem_timeout, loadmd, memwait}, 32'b0100);
      step();
      check("to_after", {29'd0, mem_req, mem_timeout, loadmd}, 32'b000);
`else
      begin
         int held = 0;
         for (int i = 0; i < 120; i++) begin
            if (mem_req === 1'b1 && loadmd === 1'b0 && mem_timeout === 1'b0) held++;
            step();
         end
         check("noto_held_cycles", 32'(held), 32'd120);
         mem_ack = 1;
         step();
         check("noto_load", {30'd0, mem_req, loadmd}, 32'b01);
         step();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
